// File: rtl/bp_update_scheduler_if.sv
// Branch-resolution / predictor-update bundle for bp_update_scheduler.
//   res_valid_a/b, res_pc_a/b, res_taken_a/b, res_mispred_a/b : resolution ports
//                                  (A is the older branch, B the younger)
//   res_ready   : scheduler can accept two entries this cycle
//   upd_wr_en   : PHT/GHR update strobe to the predictor
//   upd_pc      : PC of the update
//   upd_taken   : direction of the update
//   upd_flush   : speculative-GHR restore request (predictor must_flush)
//   fifo_count  : number of occupied queue entries
// Modports: master = resolution producer / update consumer, slave = scheduler.
interface bp_update_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                     res_valid_a;
  logic                     res_valid_b;
  logic [31:0]              res_pc_a;
  logic [31:0]              res_pc_b;
  logic                     res_taken_a;
  logic                     res_taken_b;
  logic                     res_mispred_a;
  logic                     res_mispred_b;
  logic                     res_ready;
  logic                     upd_wr_en;
  logic [31:0]              upd_pc;
  logic                     upd_taken;
  logic                     upd_flush;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output res_valid_a, res_valid_b, res_pc_a, res_pc_b,
           res_taken_a, res_taken_b, res_mispred_a, res_mispred_b,
    input  res_ready, upd_wr_en, upd_pc, upd_taken, upd_flush, fifo_count
  );

  modport slave (
    input  res_valid_a, res_valid_b, res_pc_a, res_pc_b,
           res_taken_a, res_taken_b, res_mispred_a, res_mispred_b,
    output res_ready, upd_wr_en, upd_pc, upd_taken, upd_flush, fifo_count
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: queues up to two branch resolutions per cycle and
// replays them one per cycle as predictor updates, in resolution order.
// After an update carrying a mispredict it idles one cycle so the predictor
// can re-seed its speculative GHR.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bp_update_scheduler_if.slave (resolution inputs, update outputs,
//           res_ready, fifo_count)
module bp_update_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bp_update_scheduler_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ISSUE  = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_b;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] push_cnt;

  logic [31:0]   pc_mem     [DEPTH];
  logic          taken_mem  [DEPTH];
  logic          mispred_mem[DEPTH];

  logic          ready;
  logic          push_a;
  logic          push_b;
  logic          pop;

  // Space for two entries is required even for a single push, so the
  // producer only ever has to look at one ready bit.
  always_comb begin
    ready = (count <= CW'(DEPTH - 2));
  end

  // B is on the wrong path when the older branch A mispredicted.
  always_comb begin
    push_a   = ready & bus.res_valid_a;
    push_b   = ready & bus.res_valid_b & ~(bus.res_valid_a & bus.res_mispred_a);
    wr_ptr_b = push_a ? (wr_ptr + AW'(1)) : wr_ptr;
    push_cnt = CW'(push_a) + CW'(push_b);
  end

  always_comb begin
    pop        = (state == ISSUE) && (count != '0);
    count_next = count + push_cnt - CW'(pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      ISSUE:   if (pop && mispred_mem[rd_ptr]) state_next = BUBBLE;
      BUBBLE:  state_next = ISSUE;
      default: state_next = ISSUE;
    endcase
  end

  // Storage is unreset; validity is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    if (push_a) begin
      pc_mem[wr_ptr]      <= bus.res_pc_a;
      taken_mem[wr_ptr]   <= bus.res_taken_a;
      mispred_mem[wr_ptr] <= bus.res_mispred_a;
    end
    if (push_b) begin
      pc_mem[wr_ptr_b]      <= bus.res_pc_b;
      taken_mem[wr_ptr_b]   <= bus.res_taken_b;
      mispred_mem[wr_ptr_b] <= bus.res_mispred_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ISSUE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr + AW'(push_cnt);
      count  <= count_next;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Outputs derive only from registered state, so reset forces them idle
  // without a separate path.
  always_comb begin
    bus.res_ready  = ready;
    bus.fifo_count = count;
    bus.upd_wr_en  = pop;
    bus.upd_pc     = pop ? pc_mem[rd_ptr]      : '0;
    bus.upd_taken  = pop ? taken_mem[rd_ptr]   : 1'b0;
    bus.upd_flush  = pop ? mispred_mem[rd_ptr] : 1'b0;
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed testbench for bp_update_scheduler (DEPTH=4).
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  bp_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

  bp_update_scheduler #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.res_valid_a   = 1'b0;
    bus.res_valid_b   = 1'b0;
    bus.res_pc_a      = '0;
    bus.res_pc_b      = '0;
    bus.res_taken_a   = 1'b0;
    bus.res_taken_b   = 1'b0;
    bus.res_mispred_a = 1'b0;
    bus.res_mispred_b = 1'b0;
  endtask

  task automatic set_a(input logic [31:0] pc, input logic t, input logic m);
    bus.res_valid_a   = 1'b1;
    bus.res_pc_a      = pc;
    bus.res_taken_a   = t;
    bus.res_mispred_a = m;
  endtask

  task automatic set_b(input logic [31:0] pc, input logic t, input logic m);
    bus.res_valid_b   = 1'b1;
    bus.res_pc_b      = pc;
    bus.res_taken_b   = t;
    bus.res_mispred_b = m;
  endtask

  task automatic chk_upd(input string tag, input logic en, input logic [31:0] pc,
                         input logic t, input logic fl);
    check({tag, "_wr_en"}, bus.upd_wr_en, en);
    check({tag, "_pc"},    bus.upd_pc,    pc);
    check({tag, "_taken"}, bus.upd_taken, t);
    check({tag, "_flush"}, bus.upd_flush, fl);
  endtask

  logic [31:0] q[$];
  int          mcount;
  int          sent;
  int          issued;
  logic        exp_pop;
  logic        accept;

  initial begin
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_count", bus.fifo_count, 0);
    check("rst_ready", bus.res_ready, 1);
    chk_upd("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_count", bus.fifo_count, 0);
    check("idle_wr_en", bus.upd_wr_en, 0);

    // Single push, one-cycle latency
    set_a(32'h100, 1'b1, 1'b0);
    tick();
    clr();
    chk_upd("single", 1'b1, 32'h100, 1'b1, 1'b0);
    check("single_count1", bus.fifo_count, 1);
    tick();
    check("single_count0", bus.fifo_count, 0);
    check("single_idle", bus.upd_wr_en, 0);

    // Dual push: A issues before B
    set_a(32'h200, 1'b0, 1'b0);
    set_b(32'h204, 1'b1, 1'b0);
    tick();
    clr();
    check("dual_count", bus.fifo_count, 2);
    chk_upd("dual_a", 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    chk_upd("dual_b", 1'b1, 32'h204, 1'b1, 1'b0);
    tick();
    check("dual_idle", bus.upd_wr_en, 0);

    // Mispredict bubble, pushes continue during it
    set_a(32'h300, 1'b0, 1'b1);
    tick();
    clr();
    chk_upd("mis_head", 1'b1, 32'h300, 1'b0, 1'b1);
    set_a(32'h304, 1'b1, 1'b0);
    set_b(32'h308, 1'b0, 1'b0);
    tick();
    clr();
    chk_upd("mis_bubble", 1'b0, 32'h0, 1'b0, 1'b0);
    check("mis_bubble_count", bus.fifo_count, 2);
    tick();
    chk_upd("mis_304", 1'b1, 32'h304, 1'b1, 1'b0);
    tick();
    chk_upd("mis_308", 1'b1, 32'h308, 1'b0, 1'b0);
    tick();
    check("mis_idle", bus.upd_wr_en, 0);

    // Wrong-path drop of B
    set_a(32'h400, 1'b1, 1'b1);
    set_b(32'h404, 1'b1, 1'b0);
    tick();
    clr();
    check("drop_count", bus.fifo_count, 1);
    chk_upd("drop_a", 1'b1, 32'h400, 1'b1, 1'b1);
    tick();
    check("drop_bubble", bus.upd_wr_en, 0);
    check("drop_count0", bus.fifo_count, 0);
    tick();
    check("drop_noB", bus.upd_wr_en, 0);

    // B-only push
    set_b(32'h700, 1'b1, 1'b0);
    tick();
    clr();
    chk_upd("bonly", 1'b1, 32'h700, 1'b1, 1'b0);
    tick();
    check("bonly_idle", bus.upd_wr_en, 0);

    // Backpressure and wrap-around: dual pushes every cycle, 20 entries
    mcount = 0;
    sent   = 0;
    issued = 0;
    for (int cyc = 0; cyc < 80 && (issued < 20); cyc++) begin
      exp_pop = (mcount > 0);
      check("bp_ready", bus.res_ready, (mcount <= DEPTH - 2));
      check("bp_count", bus.fifo_count, mcount);
      check("bp_wr_en", bus.upd_wr_en, exp_pop);
      if (exp_pop) begin
        check("bp_pc", bus.upd_pc, q[0]);
        void'(q.pop_front());
        issued++;
      end
      clr();
      accept = 1'b0;
      if (sent < 20) begin
        set_a(32'h1000 + 32'(4 * sent), 1'b0, 1'b0);
        set_b(32'h1000 + 32'(4 * (sent + 1)), 1'b1, 1'b0);
        accept = (mcount <= DEPTH - 2);
      end
      if (accept) begin
        q.push_back(32'h1000 + 32'(4 * sent));
        q.push_back(32'h1000 + 32'(4 * (sent + 1)));
        sent += 2;
      end
      mcount = mcount + (accept ? 2 : 0) - (exp_pop ? 1 : 0);
      tick();
    end
    clr();
    check("bp_issued", issued, 20);
    check("bp_drained", bus.fifo_count, 0);

    // Reset mid-operation with three entries queued
    set_a(32'h500, 1'b0, 1'b0);
    set_b(32'h504, 1'b0, 1'b0);
    tick();
    set_a(32'h508, 1'b0, 1'b0);
    set_b(32'h50c, 1'b0, 1'b0);
    tick();
    clr();
    check("mrst_count3", bus.fifo_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_wr_en", bus.upd_wr_en, 0);
    check("mrst_count", bus.fifo_count, 0);
    check("mrst_ready", bus.res_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_stale", bus.upd_wr_en, 0);
    end
    set_a(32'h600, 1'b1, 1'b0);
    tick();
    clr();
    chk_upd("mrst_new", 1'b1, 32'h600, 1'b1, 1'b0);
    tick();
    check("mrst_final_count", bus.fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
